sync_fifo_ctl: RTL
==================

Name: sync_fifo_ctl

Overview:
Parametrised single-clock FIFO and successor to the fixed FIFO. It adds arbitrary (non-power-of-two) depth, a fill-level count, programmable almost-full/almost-empty flags and a selectable first-word-fall-through read mode. Overflow/underflow are sticky error flags with an explicit clear. It sits between producer/consumer blocks in the toolkit, for example SPI TX/RX buffering.

Parameters:
WIDTH, 8, data word width in bits (>=1)
LENGTH, 4, depth in words (>=2, any integer; not restricted to powers of two)
AF_LEVEL, LENGTH-1, almost_full asserts when count >= AF_LEVEL (1..LENGTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..LENGTH-1)
FWFT, 0, 0 = registered read (data on out after pop edge); 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_cs  in  1  write chip select
wr_en  in  1  write enable; push request = wr_cs & wr_en
in  in  WIDTH  write data
rd_cs  in  1  read chip select
rd_en  in  1  read enable; pop request = rd_cs & rd_en
out  out  WIDTH  read data
err_clr  in  1  clears sticky overflow/underflow
full  out  1  count == LENGTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(LENGTH+1)  current occupancy
overflow  out  1  sticky: push attempted while full and not simultaneously popped
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (synchronous, active-high; takes priority over every other input, including mid-burst):
  - wr_ptr=0, rd_ptr=0, count=0, out=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0).
  - Memory contents are not cleared.
- Pointers run 0..LENGTH-1 and wrap explicitly to 0 after LENGTH-1 (compare, not bit truncation).
- Accept rules, evaluated each edge:
  - pop_ok = pop request & !empty.
  - push_ok = push request & (!full | pop_ok).
- Push on full with no accepted pop: the word is dropped, overflow<=1, pointers and count unchanged.
- Pop on empty: underflow<=1, rd_ptr unchanged, out holds its previous value. A simultaneous push is still accepted; there is no bypass.
- Simultaneous push_ok & pop_ok: both pointers advance, count unchanged. This is legal at full (the word is replaced) and at any intermediate level.
- count: +1 on push_ok only, -1 on pop_ok only. full, empty, almost_* are combinational from the registered count.
- FWFT=0: on a pop_ok edge, out<=mem[rd_ptr]; data is visible immediately after that edge (one-edge read latency). out holds between pops.
- FWFT=1: out = mem[rd_ptr] combinationally whenever !empty. A pop_ok edge advances to the next word. out is don't-care while empty. First word appears the cycle after its push edge.
- Sticky flags: set as above; cleared by err_clr or rst. Set has priority over err_clr in the same cycle.
- Flags are mutually consistent every cycle: never full & empty.

Optional Feature:
- Macro: FIFO_HIGH_WATER_EN.
- Defined: adds output port high_water [$clog2(LENGTH+1)]. It records the maximum count since the last rst or err_clr: updated to max(high_water, next count) each edge, reset to 0, and cleared to the current count on err_clr.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- LENGTH=4, FWFT=0: reset, push 11,22,33,44 -> full=1, count=4, almost_full=1; pop x4 -> out 11,22,33,44 after successive edges; then empty=1, overflow=0, underflow=0.
- Full FIFO (55,66,77,88), push 99,AA,BB,CC -> overflow=1, count stays 4; pops return 55,66,77,88 only; err_clr pulse -> overflow=0.
- Empty FIFO: push/pop same cycle with 66 -> underflow=1, count=1, out unchanged; next pop -> out=66.
- Wrap: LENGTH=5 (non-power-of-two); push 3/pop 2 repeated 4 times; then drain -> data returned in exact push order, pointers wrap 4->0, count never exceeds 5.
- Full, simultaneous push DD + pop -> out=oldest word, count stays 4, overflow=0; DD returned last on drain.
- FWFT=1, AE_LEVEL=1, AF_LEVEL=3: push A1 -> out=A1 next cycle with almost_empty=1; push A2,A3 -> almost_full=1, almost_empty=0; pop -> out=A2 same cycle. With FIFO_HIGH_WATER_EN, high_water=3; rst mid-sequence -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// Parametrised single-clock FIFO: arbitrary depth, occupancy count, almost flags,
// sticky overflow/underflow, optional FWFT read. Define FIFO_HIGH_WATER_EN for high_water.
module sync_fifo_ctl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LENGTH   = 4,
  parameter int unsigned AF_LEVEL = LENGTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_cs,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              in,
  input  logic                          rd_cs,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              out,
  input  logic                          err_clr,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(LENGTH+1)-1:0]   count,
`ifdef FIFO_HIGH_WATER_EN
  output logic [$clog2(LENGTH+1)-1:0]   high_water,
`endif
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned CW = $clog2(LENGTH + 1);
  localparam int unsigned PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] C_LEN = CW'(LENGTH);
  localparam logic [CW-1:0] C_AF  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE  = CW'(AE_LEVEL);
  localparam logic [PW-1:0] C_PTR_LAST = PW'(LENGTH - 1);

  logic [WIDTH-1:0] r_mem [LENGTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push_req;
  logic             w_pop_req;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_full;
  logic             w_empty;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;

  assign w_push_req = wr_cs & wr_en;
  assign w_pop_req  = rd_cs & rd_en;
  assign w_full     = (r_count == C_LEN);
  assign w_empty    = (r_count == '0);
  assign w_pop_ok   = w_pop_req & ~w_empty;
  // A pop in the same edge frees the slot, so a push at full is still accepted.
  assign w_push_ok  = w_push_req & (~w_full | w_pop_ok);

  // Explicit wrap keeps non-power-of-two depths correct.
  assign w_wr_ptr_nxt = (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop_ok)  r_rd_ptr <= w_rd_ptr_nxt;
      r_count <= w_count_nxt;
      if (w_push_req & ~w_push_ok) r_overflow <= 1'b1;
      else if (err_clr)            r_overflow <= 1'b0;
      if (w_pop_req & w_empty)     r_underflow <= 1'b1;
      else if (err_clr)            r_underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign out = r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_out;
      always_ff @(posedge clk) begin
        if (rst)           r_out <= '0;
        else if (w_pop_ok) r_out <= r_mem[r_rd_ptr];
      end
      assign out = r_out;
    end
  endgenerate

`ifdef FIFO_HIGH_WATER_EN
  logic [CW-1:0] r_high_water;
  always_ff @(posedge clk) begin
    if (rst)                            r_high_water <= '0;
    else if (err_clr)                   r_high_water <= w_count_nxt;
    else if (w_count_nxt > r_high_water) r_high_water <= w_count_nxt;
  end
  assign high_water = r_high_water;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
